temp_sensor_reader: RTL and testbench

- Front end that feeds the greenhouse temperature controller.
- Periodically reads two serial temperature sensors, one inside the greenhouse and one outside, over a shared 3-wire bus.
- Produces the registered signed greenhouse temperature and the flag "outside temperature greater than greenhouse temperature", which the controller consumes.
- Also reports a per-read valid pulse and a sensor fault flag.

---
 rtl/greenhouse_pkg.sv | 20 ++
 rtl/serial_byte_rx.sv | 61 ++++++
 rtl/temp_sensor_reader.sv | 131 +++++++++++++
 tb/tb_temp_sensor_reader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/greenhouse_pkg.sv
// Shared types and constants for the greenhouse temperature front end.
// State encoding, channel indices, sensor fault word and the signed temperature type.
package greenhouse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        SHIFT,
        DESEL,
        UPDATE
    } state_t;

    localparam logic CH_GREENHOUSE = 1'b0;
    localparam logic CH_OUTSIDE    = 1'b1;

    localparam logic [7:0] FAULT_CODE_DEFAULT = 8'h80;

    typedef logic signed [7:0] temp_t;

endpackage

// File: rtl/serial_byte_rx.sv
// Tick divider, sclk generator and 8-bit MSB-first shift register for one sensor read.
// o_done fires on the tick that returns sclk low after the 8th rising edge; o_byte then holds the word.
module serial_byte_rx #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic       i_shift,
    input  logic       i_miso,
    output logic       o_tick,
    output logic       o_sclk,
    output logic       o_done,
    output logic [7:0] o_byte
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    logic [DW-1:0] r_div;
    logic          r_sclk;
    logic [2:0]    r_falls;
    logic [7:0]    r_shift;
    logic          w_tick;

    assign w_tick = i_en && (r_div == DIV_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_sclk  <= 1'b0;
            r_falls <= 3'd0;
            r_shift <= 8'd0;
        end else begin
            // Held at zero while idle so the first tick after launch is a full period away.
            if (!i_en || r_div == DIV_MAX) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + 1'b1;
            end

            if (!i_shift) begin
                r_sclk  <= 1'b0;
                r_falls <= 3'd0;
            end else if (w_tick) begin
                r_sclk <= ~r_sclk;
                if (!r_sclk) begin
                    r_shift <= {r_shift[6:0], i_miso};
                end else begin
                    r_falls <= r_falls + 3'd1;
                end
            end
        end
    end

    assign o_tick = w_tick;
    assign o_sclk = r_sclk;
    assign o_done = w_tick && i_shift && r_sclk && (r_falls == 3'd7);
    assign o_byte = r_shift;

endmodule

// File: rtl/temp_sensor_reader.sv
// Periodically reads greenhouse and outside sensors, publishes temps, fault flags and outside>greenhouse.
// Launch to UPDATE is 36*CLK_DIV clocks; outputs and sample_valid change one clock later.
module temp_sensor_reader
    import greenhouse_pkg::*;
#(
    parameter int         CLK_DIV       = 4,
    parameter int         SAMPLE_PERIOD = 1000,
    parameter logic [7:0] FAULT_CODE    = FAULT_CODE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       miso,
    output logic       sclk,
    output logic [1:0] cs_n,
    output logic [7:0] greenhouse_temp,
    output logic [7:0] outside_temp,
    output logic       temp_g_greenhouse_temp,
    output logic       sample_valid,
    output logic [1:0] sensor_fault
);

    localparam int PW = $clog2(SAMPLE_PERIOD);
    localparam logic [PW-1:0] PERIOD_MAX = PW'(SAMPLE_PERIOD - 1);

    logic [PW-1:0] r_period;
    state_t        r_state;
    logic          r_ch;
    logic [1:0]    r_cs_n;
    logic [7:0]    r_hold;
    temp_t         r_gh;
    temp_t         r_out;
    logic          r_flag;
    logic          r_valid;
    logic [1:0]    r_fault;

    logic          w_tick;
    logic          w_done;
    logic [7:0]    w_byte;
    logic          w_gh_fault;
    logic          w_out_fault;
    temp_t         w_gh_next;
    temp_t         w_out_next;

    serial_byte_rx #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (r_state != IDLE),
        .i_shift (r_state == SHIFT),
        .i_miso  (miso),
        .o_tick  (w_tick),
        .o_sclk  (sclk),
        .o_done  (w_done),
        .o_byte  (w_byte)
    );

    // The outside word is still in the shift register during UPDATE; the greenhouse word was parked in r_hold.
    assign w_gh_fault  = (r_hold == FAULT_CODE);
    assign w_out_fault = (w_byte == FAULT_CODE);
    assign w_gh_next   = w_gh_fault  ? r_gh  : temp_t'(r_hold);
    assign w_out_next  = w_out_fault ? r_out : temp_t'(w_byte);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period <= '0;
            r_state  <= IDLE;
            r_ch     <= CH_GREENHOUSE;
            r_cs_n   <= 2'b11;
            r_hold   <= 8'd0;
            r_gh     <= '0;
            r_out    <= '0;
            r_flag   <= 1'b0;
            r_valid  <= 1'b0;
            r_fault  <= 2'b00;
        end else begin
            r_period <= (r_period == PERIOD_MAX) ? '0 : r_period + 1'b1;
            r_valid  <= 1'b0;

            case (r_state)
                IDLE: begin
                    // A wrap that lands outside IDLE is simply missed.
                    if (r_period == '0) begin
                        r_ch    <= CH_GREENHOUSE;
                        r_cs_n  <= 2'b10;
                        r_state <= SEL;
                    end
                end
                SEL: begin
                    if (w_tick) r_state <= SHIFT;
                end
                SHIFT: begin
                    if (w_done) begin
                        r_cs_n  <= 2'b11;
                        r_state <= DESEL;
                    end
                end
                DESEL: begin
                    if (w_tick) begin
                        if (r_ch == CH_GREENHOUSE) begin
                            r_hold  <= w_byte;
                            r_ch    <= CH_OUTSIDE;
                            r_cs_n  <= 2'b01;
                            r_state <= SEL;
                        end else begin
                            r_state <= UPDATE;
                        end
                    end
                end
                UPDATE: begin
                    r_gh    <= w_gh_next;
                    r_out   <= w_out_next;
                    r_fault <= {w_out_fault, w_gh_fault};
                    r_flag  <= (w_out_next > w_gh_next);
                    r_valid <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_cs_n  <= 2'b11;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cs_n                   = r_cs_n;
    assign greenhouse_temp        = r_gh;
    assign outside_temp           = r_out;
    assign temp_g_greenhouse_temp = r_flag;
    assign sample_valid           = r_valid;
    assign sensor_fault           = r_fault;

endmodule

// File: tb/tb_temp_sensor_reader.sv
// Scoreboard bench: directed sensor words feed a serial sensor model; a monitor checks each sample_valid.
module tb_temp_sensor_reader;

    localparam int CLK_DIV = 2;
    localparam int SP      = 200;

    typedef struct {
        logic [7:0] gw;
        logic [7:0] ow;
        logic [7:0] eg;
        logic [7:0] eo;
        logic       ef;
        logic [1:0] efl;
    } vec_t;

    typedef struct {
        logic [7:0] eg;
        logic [7:0] eo;
        logic       ef;
        logic [1:0] efl;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       miso;
    logic       sclk;
    logic [1:0] cs_n;
    logic [7:0] greenhouse_temp;
    logic [7:0] outside_temp;
    logic       flag;
    logic       sample_valid;
    logic [1:0] sensor_fault;

    int checks = 0;
    int errors = 0;

    logic [7:0] gh_q[$];
    logic [7:0] out_q[$];
    exp_t       exp_q[$];
    vec_t       vecs[8];

    temp_sensor_reader #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SP), .FAULT_CODE(8'h80)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .miso                   (miso),
        .sclk                   (sclk),
        .cs_n                   (cs_n),
        .greenhouse_temp        (greenhouse_temp),
        .outside_temp           (outside_temp),
        .temp_g_greenhouse_temp (flag),
        .sample_valid           (sample_valid),
        .sensor_fault           (sensor_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Sensor model: MSB presented on chip-select fall, next bit after each sclk fall.
    initial begin
        logic [1:0] p_cs;
        logic       p_sclk;
        logic [7:0] sh;
        p_cs   = 2'b11;
        p_sclk = 1'b0;
        sh     = 8'd0;
        miso   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (p_cs[0] && !cs_n[0]) begin
                sh = 8'd0;
                if (gh_q.size() > 0) sh = gh_q.pop_front();
                miso = sh[7];
            end else if (p_cs[1] && !cs_n[1]) begin
                sh = 8'd0;
                if (out_q.size() > 0) sh = out_q.pop_front();
                miso = sh[7];
            end else if (p_sclk && !sclk) begin
                sh   = {sh[6:0], 1'b0};
                miso = sh[7];
            end
            p_cs   = cs_n;
            p_sclk = sclk;
        end
    end

    // Monitor: bus protocol every cycle, scoreboard compare on each sample_valid.
    initial begin
        int   rises;
        logic m_sclk;
        exp_t e;
        rises  = 0;
        m_sclk = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rises = 0;
            end else begin
                chk("cs_both_low", (cs_n == 2'b00), 0);
                if (cs_n == 2'b11) chk("sclk_idle_low", sclk, 0);
                if (sclk && !m_sclk) rises++;
                if (sample_valid) begin
                    chk("sclk_rises_per_sample", rises, 16);
                    rises = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid actual=1 required=0 at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("greenhouse_temp", greenhouse_temp, e.eg);
                        chk("outside_temp", outside_temp, e.eo);
                        chk("temp_g_greenhouse_temp", flag, e.ef);
                        chk("sensor_fault", sensor_fault, e.efl);
                    end
                end
            end
            m_sclk = sclk;
        end
    end

    task automatic check_launch(input string tag);
        int k;
        int fall;
        bit got;
        k    = 0;
        fall = 0;
        got  = 0;
        while (k < 400 && !got) begin
            @(negedge clk);
            k++;
            if (fall == 0 && !cs_n[0]) fall = k;
            if (sample_valid) got = 1;
        end
        chk({tag, "_cs0_fall_cycle_ok"}, (fall >= 1 && fall <= CLK_DIV + 1), 1);
        chk({tag, "_first_valid_cycle_ok"},
            (got && k >= 36 * CLK_DIV + 1 && k <= 36 * CLK_DIV + 3), 1);
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_scoreboard_left"}, exp_q.size(), 0);
    endtask

    initial begin
        int t;
        int r;
        logic ps;

        vecs[0] = '{8'd25, 8'd30, 8'd25, 8'd30, 1'b1, 2'b00};
        vecs[1] = '{8'hFB, 8'hF6, 8'hFB, 8'hF6, 1'b0, 2'b00};
        vecs[2] = '{8'hF6, 8'hF6, 8'hF6, 8'hF6, 1'b0, 2'b00};
        vecs[3] = '{8'hF6, 8'h01, 8'hF6, 8'h01, 1'b1, 2'b00};
        vecs[4] = '{8'd20, 8'd30, 8'd20, 8'd30, 1'b1, 2'b00};
        vecs[5] = '{8'd20, 8'h80, 8'd20, 8'd30, 1'b1, 2'b10};
        vecs[6] = '{8'd20, 8'd12, 8'd20, 8'd12, 1'b0, 2'b00};
        vecs[7] = '{8'h80, 8'd12, 8'd20, 8'd12, 1'b0, 2'b01};

        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_sclk", sclk, 0);
        chk("rst_cs_n", cs_n, 2'b11);
        chk("rst_greenhouse_temp", greenhouse_temp, 0);
        chk("rst_outside_temp", outside_temp, 0);
        chk("rst_flag", flag, 0);
        chk("rst_sample_valid", sample_valid, 0);
        chk("rst_sensor_fault", sensor_fault, 2'b00);

        foreach (vecs[i]) begin
            gh_q.push_back(vecs[i].gw);
            out_q.push_back(vecs[i].ow);
            exp_q.push_back('{vecs[i].eg, vecs[i].eo, vecs[i].ef, vecs[i].efl});
        end
        rst_n = 1'b1;
        check_launch("boot");
        drain("vectors");

        // Abort the next pair after the 4th sclk rise on the outside sensor.
        gh_q.push_back(8'd40);
        out_q.push_back(8'd50);
        t  = 0;
        r  = 0;
        ps = sclk;
        while (t < 1000 && !(cs_n == 2'b01 && r == 4)) begin
            @(posedge clk);
            #1;
            t++;
            if (cs_n == 2'b01 && sclk && !ps) r++;
            ps = sclk;
        end
        chk("mid_shift_reached", (t < 1000), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cs_n", cs_n, 2'b11);
        chk("mid_rst_sclk", sclk, 0);
        chk("mid_rst_greenhouse_temp", greenhouse_temp, 0);
        chk("mid_rst_outside_temp", outside_temp, 0);
        chk("mid_rst_flag", flag, 0);
        chk("mid_rst_sensor_fault", sensor_fault, 2'b00);
        chk("mid_rst_sample_valid", sample_valid, 0);
        repeat (5) @(posedge clk);
        gh_q.push_back(8'd7);
        out_q.push_back(8'd9);
        exp_q.push_back('{8'd7, 8'd9, 1'b1, 2'b00});
        @(negedge clk);
        rst_n = 1'b1;
        check_launch("relaunch");
        drain("relaunch");
        chk("sensor_words_left", gh_q.size() + out_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
